// File: rtl/nf1_cml_pkg.sv
// rtl/nf1_cml_pkg.sv - shared types, default widths and round-robin helper for the input arbiter
package nf1_cml_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    localparam int C_DEF_DATA_WIDTH  = 256;
    localparam int C_DEF_TUSER_WIDTH = 128;

    // First requester strictly after 'last' in rotation order; caller guarantees req != 0.
    function automatic logic [2:0] next_rr(input logic [7:0] req, input logic [2:0] last, input int n);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = (int'(last) + k) % n;
            if (!found && k <= n && req[3'(idx)]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/nf1_axis_reg_slice.sv
// rtl/nf1_axis_reg_slice.sv - single-entry AXI-Stream output register
module nf1_axis_reg_slice #(
    parameter int DW = 256,
    parameter int SW = 32,
    parameter int UW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] in_tdata,
    input  logic [SW-1:0] in_tstrb,
    input  logic [UW-1:0] in_tuser,
    input  logic          in_tlast,
    input  logic          m_axis_tready,
    output logic [DW-1:0] m_axis_tdata,
    output logic [SW-1:0] m_axis_tstrb,
    output logic [UW-1:0] m_axis_tuser,
    output logic          m_axis_tvalid,
    output logic          m_axis_tlast
);

    logic [DW-1:0] tdata_q, tdata_d;
    logic [SW-1:0] tstrb_q, tstrb_d;
    logic [UW-1:0] tuser_q, tuser_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;

    // The caller only asserts load when the slot is empty or draining, so held data never changes.
    always_comb begin
        tdata_d  = tdata_q;
        tstrb_d  = tstrb_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        if (load) begin
            tdata_d  = in_tdata;
            tstrb_d  = in_tstrb;
            tuser_d  = in_tuser;
            tlast_d  = in_tlast;
            tvalid_d = 1'b1;
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdata_q  <= '0;
            tstrb_q  <= '0;
            tuser_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            tdata_q  <= tdata_d;
            tstrb_q  <= tstrb_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tstrb  = tstrb_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;

endmodule

// File: rtl/nf1_cml_input_arbiter.sv
// rtl/nf1_cml_input_arbiter.sv - packet-granular round-robin merge of the MAC RX streams
module nf1_cml_input_arbiter
    import nf1_cml_pkg::*;
#(
    parameter int C_NUM_PORTS   = 4,
    parameter int C_DATA_WIDTH  = C_DEF_DATA_WIDTH,
    parameter int C_TUSER_WIDTH = C_DEF_TUSER_WIDTH
) (
    input  logic                                 axi_aclk,
    input  logic                                 axi_aresetn,
    input  logic [C_NUM_PORTS*C_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [C_NUM_PORTS*C_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [C_NUM_PORTS*C_TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [C_NUM_PORTS-1:0]               s_axis_tvalid,
    output logic [C_NUM_PORTS-1:0]               s_axis_tready,
    input  logic [C_NUM_PORTS-1:0]               s_axis_tlast,
    output logic [C_DATA_WIDTH-1:0]              m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]            m_axis_tstrb,
    output logic [C_TUSER_WIDTH-1:0]             m_axis_tuser,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast,
    output logic [2:0]                           grant_id,
    output logic                                 busy
);

    localparam int SW = C_DATA_WIDTH / 8;

    state_t                   state_q, state_d;
    logic [2:0]               grant_q, grant_d;
    logic [2:0]               last_grant_q, last_grant_d;
    logic [C_DATA_WIDTH-1:0]  sel_tdata;
    logic [SW-1:0]            sel_tstrb;
    logic [C_TUSER_WIDTH-1:0] sel_tuser;
    logic                     sel_tvalid;
    logic                     sel_tlast;
    logic                     slot_free;
    logic                     accept;

    always_comb begin
        sel_tdata  = '0;
        sel_tstrb  = '0;
        sel_tuser  = '0;
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        for (int i = 0; i < C_NUM_PORTS; i++) begin
            if (grant_q == 3'(i)) begin
                sel_tdata  = s_axis_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH];
                sel_tstrb  = s_axis_tstrb[i*SW +: SW];
                sel_tuser  = s_axis_tuser[i*C_TUSER_WIDTH +: C_TUSER_WIDTH];
                sel_tvalid = s_axis_tvalid[i];
                sel_tlast  = s_axis_tlast[i];
            end
        end
    end

    assign slot_free = !m_axis_tvalid || m_axis_tready;
    assign accept    = (state_q == PKT) && sel_tvalid && slot_free;

    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < C_NUM_PORTS; i++) begin
            s_axis_tready[i] = (state_q == PKT) && (grant_q == 3'(i)) && slot_free;
        end
    end

    // The grant is held across tvalid gaps; only an accepted tlast releases it.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (|s_axis_tvalid) begin
                    state_d = PKT;
                    grant_d = next_rr(8'(s_axis_tvalid), last_grant_q, C_NUM_PORTS);
                end
            end
            PKT: begin
                if (accept && sel_tlast) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q      <= IDLE;
            grant_q      <= 3'd0;
            last_grant_q <= 3'(C_NUM_PORTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == PKT);

    nf1_axis_reg_slice #(
        .DW(C_DATA_WIDTH),
        .SW(SW),
        .UW(C_TUSER_WIDTH)
    ) u_out_reg (
        .clk          (axi_aclk),
        .rst_n        (axi_aresetn),
        .load         (accept),
        .in_tdata     (sel_tdata),
        .in_tstrb     (sel_tstrb),
        .in_tuser     (sel_tuser),
        .in_tlast     (sel_tlast),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tstrb (m_axis_tstrb),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast)
    );

endmodule

// File: tb/tb_nf1_cml_input_arbiter.sv
// tb/tb_nf1_cml_input_arbiter.sv - self-checking bench for the round-robin input arbiter
module tb_nf1_cml_input_arbiter;

    localparam int NP = 4;
    localparam int DW = 256;
    localparam int SW = 32;
    localparam int UW = 128;

    logic              axi_aclk = 1'b0;
    logic              axi_aresetn = 1'b0;
    logic [NP*DW-1:0]  s_axis_tdata = '0;
    logic [NP*SW-1:0]  s_axis_tstrb = '0;
    logic [NP*UW-1:0]  s_axis_tuser = '0;
    logic [NP-1:0]     s_axis_tvalid = '0;
    logic [NP-1:0]     s_axis_tready;
    logic [NP-1:0]     s_axis_tlast = '0;
    logic [DW-1:0]     m_axis_tdata;
    logic [SW-1:0]     m_axis_tstrb;
    logic [UW-1:0]     m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic              m_axis_tlast;
    logic [2:0]        grant_id;
    logic              busy;

    always #5 axi_aclk = ~axi_aclk;

    nf1_cml_input_arbiter #(.C_NUM_PORTS(NP), .C_DATA_WIDTH(DW), .C_TUSER_WIDTH(UW)) dut (
        .axi_aclk     (axi_aclk),
        .axi_aresetn  (axi_aresetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tstrb (s_axis_tstrb),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tstrb (m_axis_tstrb),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
        int            gap;
    } beat_t;

    beat_t pq[NP][$];
    beat_t exp_q[$];
    beat_t out_q[$];
    int    out_cyc[$];
    int    total = 0;
    int    bad = 0;
    int    viol;
    int    seq_bad;
    bit    timed_out;
    int    hold_beat = -1;
    int    hold_len = 0;

    task automatic do_reset();
        @(negedge axi_aclk);
        axi_aresetn   = 1'b0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b0;
        for (int i = 0; i < NP; i++) pq[i].delete();
        repeat (2) @(negedge axi_aclk);
        axi_aresetn = 1'b1;
    endtask

    task automatic add_pkt(input int port, input int pkt, input int len, input int gap_pct, input logic [DW-1:0] base);
        for (int j = 0; j < len; j++) begin
            beat_t b;
            for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
            b.data[DW-1 -: 24] = {8'(port), 8'(pkt), 8'(j)};
            if (base != '0) b.data = base + DW'(j);
            b.strb = $urandom;
            b.user = {$urandom, $urandom, $urandom, $urandom};
            b.last = (j == len - 1);
            b.gap  = (j > 0 && int'($urandom_range(99)) < gap_pct) ? int'($urandom_range(2, 1)) : 0;
            pq[port].push_back(b);
        end
    endtask

    // Drives the queued packets, records the merged stream and builds the expected stream
    // from the rotation rule: next non-empty port after the last served one, whole packets.
    task automatic run(input int stall_pct, input int budget);
        beat_t          mq[NP][$];
        beat_t          b;
        int             last_p, p, q;
        int             gap_left[NP];
        int             hold_left;
        bit             hold_done, stall_prev, all_empty;
        logic [DW+SW+UW+1:0] prev_o, cur_o;

        for (int i = 0; i < NP; i++) mq[i] = pq[i];
        exp_q.delete();
        last_p = NP - 1;
        while (1) begin
            p = -1;
            for (int k = 1; k <= NP; k++) begin
                q = (last_p + k) % NP;
                if (p < 0 && mq[q].size() > 0) p = q;
            end
            if (p < 0) break;
            do begin
                b = mq[p].pop_front();
                exp_q.push_back(b);
            end while (!b.last);
            last_p = p;
        end

        out_q.delete();
        out_cyc.delete();
        viol = 0;
        seq_bad = 0;
        timed_out = 1;
        hold_left = 0;
        hold_done = 0;
        stall_prev = 0;
        prev_o = '0;
        for (int i = 0; i < NP; i++) gap_left[i] = (pq[i].size() > 0) ? pq[i][0].gap : 0;

        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge axi_aclk);
            for (int i = 0; i < NP; i++) begin
                if (pq[i].size() > 0 && gap_left[i] == 0) begin
                    s_axis_tvalid[i]         = 1'b1;
                    s_axis_tdata[i*DW +: DW] = pq[i][0].data;
                    s_axis_tstrb[i*SW +: SW] = pq[i][0].strb;
                    s_axis_tuser[i*UW +: UW] = pq[i][0].user;
                    s_axis_tlast[i]          = pq[i][0].last;
                end else begin
                    s_axis_tvalid[i] = 1'b0;
                    s_axis_tlast[i]  = 1'b0;
                    if (gap_left[i] > 0) gap_left[i]--;
                end
            end
            if (hold_left == 0 && !hold_done && m_axis_tvalid && out_q.size() == hold_beat) begin
                hold_done = 1;
                hold_left = hold_len;
            end
            if (hold_left > 0) begin
                m_axis_tready = 1'b0;
                hold_left--;
            end else begin
                m_axis_tready = (int'($urandom_range(99)) >= stall_pct);
            end
            #4;
            if ((s_axis_tready & ~(4'b0001 << grant_id)) != 4'b0000) viol++;
            if (m_axis_tvalid && !m_axis_tready && s_axis_tready != 4'b0000) viol++;
            cur_o = {m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast};
            if (stall_prev && cur_o != prev_o) viol++;
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_o = cur_o;
            if (m_axis_tvalid && m_axis_tready) begin
                b.data = m_axis_tdata;
                b.strb = m_axis_tstrb;
                b.user = m_axis_tuser;
                b.last = m_axis_tlast;
                b.gap  = 0;
                out_q.push_back(b);
                out_cyc.push_back(cyc);
            end
            all_empty = 1;
            for (int i = 0; i < NP; i++) begin
                if (s_axis_tvalid[i] && s_axis_tready[i]) begin
                    void'(pq[i].pop_front());
                    gap_left[i] = (pq[i].size() > 0) ? pq[i][0].gap : 0;
                end
                if (pq[i].size() > 0) all_empty = 0;
            end
            if (all_empty && out_q.size() >= exp_q.size()) begin
                timed_out = 0;
                break;
            end
        end
        for (int j = 0; j < exp_q.size() && j < out_q.size(); j++) begin
            if (out_q[j].data !== exp_q[j].data || out_q[j].strb !== exp_q[j].strb ||
                out_q[j].user !== exp_q[j].user || out_q[j].last !== exp_q[j].last) seq_bad++;
        end
    endtask

    task automatic test_reset();
        axi_aresetn   = 1'b0;
        s_axis_tvalid = 4'b1111;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge axi_aclk);
        total += 6;
        if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        if (m_axis_tdata !== '0) begin bad++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
        if (m_axis_tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
        if (s_axis_tready !== 4'b0000) begin bad++; $display("FAIL reset_s_tready: got %b want 0000", s_axis_tready); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (grant_id !== 3'd0) begin bad++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    endtask

    task automatic test_single_port();
        do_reset();
        add_pkt(0, 0, 3, 0, 256'hA0);
        run(0, 60);
        total += 5;
        if (timed_out !== 1'b0) begin bad++; $display("FAIL single_timeout: got %0d want 0", timed_out); end
        if (out_q.size() !== 3) begin bad++; $display("FAIL single_count: got %0d want 3", out_q.size()); end
        if (seq_bad !== 0) begin bad++; $display("FAIL single_seq: got %0d bad beats want 0", seq_bad); end
        if (viol !== 0) begin bad++; $display("FAIL single_protocol: got %0d want 0", viol); end
        if (grant_id !== 3'd0) begin bad++; $display("FAIL single_grant: got %0d want 0", grant_id); end
        if (out_q.size() == 3) begin
            total += 4;
            if (out_q[0].data !== 256'hA0) begin bad++; $display("FAIL single_first_data: got %h want a0", out_q[0].data); end
            if (out_cyc[0] !== 2) begin bad++; $display("FAIL single_latency: got %0d want 2", out_cyc[0]); end
            if (out_cyc[2] - out_cyc[0] !== 2) begin bad++; $display("FAIL single_consecutive: got %0d want 2", out_cyc[2] - out_cyc[0]); end
            if (out_q[2].last !== 1'b1 || out_q[1].last !== 1'b0) begin
                bad++; $display("FAIL single_tlast: got %b%b want 10", out_q[2].last, out_q[1].last);
            end
        end
    endtask

    task automatic test_two_ports();
        logic [31:0] order;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            add_pkt(0, k, 2, 0, '0);
            add_pkt(2, k, 2, 0, '0);
        end
        run(0, 100);
        order = '0;
        foreach (out_q[j]) if (out_q[j].last) order = (order << 4) | 32'(out_q[j].data[DW-1 -: 8]);
        total += 4;
        if (timed_out !== 1'b0) begin bad++; $display("FAIL two_timeout: got %0d want 0", timed_out); end
        if (order !== 32'h0202) begin bad++; $display("FAIL two_order: got %h want 0202", order); end
        if (seq_bad !== 0) begin bad++; $display("FAIL two_seq: got %0d want 0", seq_bad); end
        if (viol !== 0) begin bad++; $display("FAIL two_protocol: got %0d want 0", viol); end
    endtask

    task automatic test_all_single_beat();
        logic [31:0] order;
        int          sp_bad;
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < NP; p++) add_pkt(p, k, 1, 0, '0);
        run(0, 100);
        order = '0;
        sp_bad = 0;
        foreach (out_q[j]) if (out_q[j].last) order = (order << 4) | 32'(out_q[j].data[DW-1 -: 8]);
        for (int j = 1; j < out_cyc.size(); j++) if (out_cyc[j] - out_cyc[j-1] != 2) sp_bad++;
        total += 5;
        if (order !== 32'h01230123) begin bad++; $display("FAIL rr_order: got %h want 01230123", order); end
        if (out_q.size() !== 8) begin bad++; $display("FAIL rr_count: got %0d want 8", out_q.size()); end
        if (sp_bad !== 0) begin bad++; $display("FAIL rr_bubble: got %0d off-spacing beats want 0", sp_bad); end
        if (seq_bad !== 0) begin bad++; $display("FAIL rr_seq: got %0d want 0", seq_bad); end
        if (viol !== 0) begin bad++; $display("FAIL rr_protocol: got %0d want 0", viol); end
    endtask

    task automatic test_backpressure();
        do_reset();
        add_pkt(1, 0, 4, 0, '0);
        hold_beat = 1;
        hold_len  = 5;
        run(0, 100);
        hold_beat = -1;
        total += 4;
        if (out_q.size() !== 4) begin bad++; $display("FAIL bp_count: got %0d want 4", out_q.size()); end
        if (seq_bad !== 0) begin bad++; $display("FAIL bp_seq: got %0d want 0", seq_bad); end
        if (viol !== 0) begin bad++; $display("FAIL bp_protocol: got %0d want 0", viol); end
        if (out_cyc.size() >= 3) begin
            if (out_cyc[1] - out_cyc[0] !== 6) begin bad++; $display("FAIL bp_hold: got %0d want 6", out_cyc[1] - out_cyc[0]); end
        end else begin
            bad++; $display("FAIL bp_hold: got %0d beats want 4", out_cyc.size());
        end
    endtask

    task automatic test_grant_hold();
        logic [31:0] order;
        beat_t       b;
        do_reset();
        add_pkt(0, 0, 1, 0, '0);
        add_pkt(0, 1, 1, 0, '0);
        add_pkt(3, 0, 4, 0, '0);
        b = pq[3][1];
        b.gap = 3;
        pq[3][1] = b;
        run(0, 100);
        order = '0;
        foreach (out_q[j]) if (out_q[j].last) order = (order << 4) | 32'(out_q[j].data[DW-1 -: 8]);
        total += 3;
        if (order !== 32'h030) begin bad++; $display("FAIL hold_order: got %h want 030", order); end
        if (seq_bad !== 0) begin bad++; $display("FAIL hold_seq: got %0d want 0", seq_bad); end
        if (viol !== 0) begin bad++; $display("FAIL hold_protocol: got %0d want 0", viol); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int p = 0; p < NP; p++)
                for (int k = 0; k < int'($urandom_range(4)); k++)
                    add_pkt(p, k, int'($urandom_range(5, 1)), 30, '0);
            run(30, 4000);
            total += 4;
            if (timed_out !== 1'b0) begin bad++; $display("FAIL rand%0d_timeout: got %0d want 0", r, timed_out); end
            if (out_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand%0d_count: got %0d want %0d", r, out_q.size(), exp_q.size()); end
            if (seq_bad !== 0) begin bad++; $display("FAIL rand%0d_seq: got %0d want 0", r, seq_bad); end
            if (viol !== 0) begin bad++; $display("FAIL rand%0d_protocol: got %0d want 0", r, viol); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] order;
        do_reset();
        @(negedge axi_aclk);
        s_axis_tvalid = 4'b0100;
        s_axis_tdata[2*DW +: DW] = {8{$urandom}};
        s_axis_tuser[2*UW +: UW] = {4{$urandom}};
        s_axis_tlast  = 4'b0000;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge axi_aclk);
        total += 3;
        if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
        if (grant_id !== 3'd2) begin bad++; $display("FAIL mid_grant: got %0d want 2", grant_id); end
        if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL mid_tvalid: got %b want 1", m_axis_tvalid); end
        #2;
        axi_aresetn = 1'b0;
        #1;
        total += 5;
        if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL async_tvalid: got %b want 0", m_axis_tvalid); end
        if (m_axis_tdata !== '0 || m_axis_tuser !== '0) begin bad++; $display("FAIL async_data: got %h want 0", m_axis_tdata); end
        if (s_axis_tready !== 4'b0000) begin bad++; $display("FAIL async_s_tready: got %b want 0000", s_axis_tready); end
        if (busy !== 1'b0) begin bad++; $display("FAIL async_busy: got %b want 0", busy); end
        if (grant_id !== 3'd0) begin bad++; $display("FAIL async_grant: got %0d want 0", grant_id); end
        @(negedge axi_aclk);
        s_axis_tvalid = '0;
        axi_aresetn   = 1'b1;
        add_pkt(2, 1, 2, 0, '0);
        add_pkt(0, 0, 1, 0, '0);
        run(0, 100);
        order = '0;
        foreach (out_q[j]) if (out_q[j].last) order = (order << 4) | 32'(out_q[j].data[DW-1 -: 8]);
        total += 2;
        if (order !== 32'h02) begin bad++; $display("FAIL mid_restart_order: got %h want 02", order); end
        if (seq_bad !== 0) begin bad++; $display("FAIL mid_restart_seq: got %0d want 0", seq_bad); end
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_two_ports();
        test_all_single_beat();
        test_backpressure();
        test_grant_hold();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
